// File: rtl/serial_alu_sequencer_if.sv
// Start/operand/result bundle for serial_alu_sequencer.
// The abort input exists only when SERIAL_ALU_ABORT_EN is defined.
interface serial_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             binv;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ALU_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
`ifdef SERIAL_ALU_ABORT_EN
    output abort,
`endif
    output start, op, binv, a, b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
`ifdef SERIAL_ALU_ABORT_EN
    input  abort,
`endif
    input  start, op, binv, a, b,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU: one slice step per clock, LSB first (and/or/add/sub/slt).
// Optional macro SERIAL_ALU_ABORT_EN adds an abort input that cancels a running operation.
module serial_alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] sr_q;
  logic [1:0]       op_q;
  logic             binv_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;

  logic             sub_mode;
  logic             b_eff;
  logic             slice_bit;
  logic             slice_cout;
  logic [WIDTH-1:0] word_d;
  logic             v_d;
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;
  logic             abort_run;

`ifdef SERIAL_ALU_ABORT_EN
  assign abort_run = bus.abort;
`else
  assign abort_run = 1'b0;
`endif

  // slt always subtracts; binv only matters for op=10
  assign sub_mode = (op_q == 2'b11) || ((op_q == 2'b10) && binv_q);
  assign b_eff    = b_q[0] ^ sub_mode;

  always_comb begin
    slice_bit  = 1'b0;
    slice_cout = 1'b0;
    case (op_q)
      2'b00: slice_bit = a_q[0] & b_q[0];
      2'b01: slice_bit = a_q[0] | b_q[0];
      default: begin
        slice_bit  = a_q[0] ^ b_eff ^ carry_q;
        slice_cout = (a_q[0] & b_eff) | (carry_q & (a_q[0] ^ b_eff));
      end
    endcase
  end

  // On the last step carry_q is the carry into the MSB
  assign word_d = {slice_bit, sr_q};
  assign v_d    = carry_q ^ slice_cout;

  always_comb begin
    result_d = word_d;
    ovf_d    = 1'b0;
    case (op_q)
      2'b10: ovf_d = v_d;
      2'b11: result_d = {{(WIDTH-1){1'b0}}, slice_bit ^ v_d};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sr_q     <= '0;
      op_q     <= 2'b00;
      binv_q   <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            binv_q  <= bus.binv;
            carry_q <= (bus.op == 2'b11) || ((bus.op == 2'b10) && bus.binv);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_run) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sr_q    <= word_d[WIDTH-1:1];
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= result_d;
              zero_q   <= (result_d == '0);
              ovf_q    <= ovf_d;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer: vector table plus multi-cycle corner sequences.
// Define SERIAL_ALU_ABORT_EN to also exercise the abort input.
module tb_serial_alu_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_alu_sequencer_if #(.WIDTH(W)) bus ();

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]   op;
    logic         binv;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z;
    logic         v;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start at cycle T, then expect done exactly at T+W+1 with busy for W cycles
  task automatic run_op(input int id, input vec_t v);
    int n;
    int busy_cnt;
    bus.op    = v.op;
    bus.binv  = v.binv;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && n <= W + 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      n++;
    end
    chk($sformatf("v%0d_done_seen", id), 64'(bus.done), 64'(1));
    chk($sformatf("v%0d_done_latency", id), 64'(n), 64'(W + 1));
    chk($sformatf("v%0d_busy_cycles", id), 64'(busy_cnt), 64'(W));
    chk($sformatf("v%0d_busy_at_done", id), 64'(bus.busy), 64'(0));
    chk($sformatf("v%0d_result", id), 64'(bus.result), 64'(v.r));
    chk($sformatf("v%0d_zero", id), 64'(bus.zero), 64'(v.z));
    chk($sformatf("v%0d_overflow", id), 64'(bus.overflow), 64'(v.v));
    $display("txn %0d op=%0d binv=%0d a=%h b=%h -> result=%h zero=%0d ovf=%0d",
             id, v.op, v.binv, v.a, v.b, bus.result, bus.zero, bus.overflow);
    tick();
    chk($sformatf("v%0d_done_one_cycle", id), 64'(bus.done), 64'(0));
  endtask

  initial begin
    int n;
    int dseen;

    vecs[0]  = '{2'b10, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[1]  = '{2'b10, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[3]  = '{2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{2'b11, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[10] = '{2'b10, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{2'b00, 1'b1, 32'h1234_5678, 32'h0000_00FF, 32'h0000_0078, 1'b0, 1'b0};
    vecs[12] = '{2'b11, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vecs[13] = '{2'b10, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
    vecs[14] = '{2'b11, 1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0001, 1'b0, 1'b0};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.binv  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ALU_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_result", 64'(bus.result), 64'(0));
    chk("reset_zero", 64'(bus.zero), 64'(1));
    chk("reset_overflow", 64'(bus.overflow), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_op(i, vecs[i]);

    // Second start during RUN ignored; start held through DONE is taken only in IDLE
    bus.op = 2'b10; bus.binv = 1'b0; bus.a = 32'd1; bus.b = 32'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 6;
    while (bus.done !== 1'b1 && n <= W + 20) begin
      tick();
      n++;
    end
    chk("busy_start_done_latency", 64'(n), 64'(W + 1));
    chk("busy_start_result", 64'(bus.result), 64'(3));
    $display("txn ignored-start: result=%h at T+%0d", bus.result, n);
    bus.a = 32'd4; bus.b = 32'd5; bus.start = 1'b1;
    tick();
    chk("start_in_done_ignored", 64'(bus.busy), 64'(0));
    chk("no_second_done", 64'(bus.done), 64'(0));
    tick();
    chk("start_in_idle_accepted", 64'(bus.busy), 64'(1));
    bus.start = 1'b0;
    n = W + 35 - (W + 1) + 1;
    n = 35;
    while (bus.done !== 1'b1 && n <= W + 60) begin
      tick();
      n++;
    end
    chk("restart_done_latency", 64'(n), 64'(W + 35));
    chk("restart_result", 64'(bus.result), 64'(9));
    $display("txn restart: result=%h", bus.result);
    tick();

    // Reset in the middle of an add discards it
    bus.a = 32'd1; bus.b = 32'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_busy", 64'(bus.busy), 64'(0));
    chk("midreset_result", 64'(bus.result), 64'(0));
    chk("midreset_zero", 64'(bus.zero), 64'(1));
    dseen = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) dseen++;
    end
    chk("midreset_no_done", 64'(dseen), 64'(0));
    $display("txn midreset: busy=%0d result=%h", bus.busy, bus.result);

`ifdef SERIAL_ALU_ABORT_EN
    run_op(100, '{2'b10, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0});
    bus.op = 2'b10; bus.binv = 1'b0; bus.a = 32'd100; bus.b = 32'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_result_kept", 64'(bus.result), 64'(30));
    chk("abort_zero_kept", 64'(bus.zero), 64'(0));
    dseen = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) dseen++;
    end
    chk("abort_no_done", 64'(dseen), 64'(0));
    $display("txn abort: busy=%0d result=%h", bus.busy, bus.result);

    // abort together with start in IDLE: start wins
    bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_start_accepted", 64'(bus.busy), 64'(1));
    n = 1;
    while (bus.done !== 1'b1 && n <= W + 20) begin
      tick();
      n++;
    end
    chk("abort_start_latency", 64'(n), 64'(W + 1));
    chk("abort_start_result", 64'(bus.result), 64'(13));
    $display("txn abort+start: result=%h", bus.result);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
